// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared constants for the ID stage.
//   - MIPS opcode and R-type funct codes for the decoded subset
//   - aluc encodings driven towards EX
//   - pcsource encodings returned to fetch
package id_stage_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;

  // Next-PC source selection
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: bundles every ID-stage signal except clk/clrn.
//   modport slave  : the ID stage (consumes fetch/EX/MEM/WB inputs, drives decode outputs)
//   modport master : the surrounding pipeline (or a bench) driving the ID stage
interface id_stage_if;
  // From fetch
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  // Register-file write port from WB
  logic        wb_we;
  logic [4:0]  wb_rn;
  logic [31:0] wb_data;
  // EX / MEM hazard and forwarding sources
  logic        ex_wreg;
  logic        ex_m2reg;
  logic [4:0]  ex_rn;
  logic [31:0] ex_alu;
  logic        mem_wreg;
  logic [4:0]  mem_rn;
  logic [31:0] mem_data;
  // Back to fetch
  logic        stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  // Towards EX
  logic [31:0] da;
  logic [31:0] db;
  logic [31:0] imm;
  logic [4:0]  rn;
  logic [3:0]  aluc;
  logic        wreg;
  logic        m2reg;
  logic        wmem;
  logic        aluimm;

  modport slave (
    input  if_inst, if_pc4, wb_we, wb_rn, wb_data,
    input  ex_wreg, ex_m2reg, ex_rn, ex_alu, mem_wreg, mem_rn, mem_data,
    output stall, pcsource, bpc, jpc, da, db, imm, rn, aluc, wreg, m2reg, wmem, aluimm
  );

  modport master (
    output if_inst, if_pc4, wb_we, wb_rn, wb_data,
    output ex_wreg, ex_m2reg, ex_rn, ex_alu, mem_wreg, mem_rn, mem_data,
    input  stall, pcsource, bpc, jpc, da, db, imm, rn, aluc, wreg, m2reg, wmem, aluimm
  );
endinterface

// File: rtl/id_regfile.sv
// id_regfile: NREG x 32 register file, two combinational read ports, one write port.
//   clk_i            write clock
//   ra1_i, ra2_i     read addresses;  rd1_o, rd2_o read data
//   we_i, wn_i, wd_i write enable / address / data
// Register 0 always reads zero and is never written. A write landing in the same
// cycle as a read of that register is bypassed onto the read port. No reset of contents.
module id_regfile #(
  parameter int unsigned NREG = 32
) (
  input  logic        clk_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wn_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (we_i && wn_i != 5'd0) begin
      regs_q[wn_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    if (ra1_i != 5'd0) begin
      rd1_o = (we_i && wn_i == ra1_i) ? wd_i : regs_q[ra1_i];
    end
  end

  always_comb begin
    rd2_o = '0;
    if (ra2_i != 5'd0) begin
      rd2_o = (we_i && wn_i == ra2_i) ? wd_i : regs_q[ra2_i];
    end
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS-subset instruction decode stage.
//   clk   rising-edge clock for all state
//   clrn  synchronous active-high reset (IF/ID loaded with a NOP and RESET_PC4)
//   bus   id_stage_if.slave: fetch inputs, WB write port, EX/MEM hazard sources,
//         and the decoded control/operand outputs plus stall/pcsource/bpc/jpc to fetch.
// Holds the IF/ID register and register file, resolves branches/jumps in ID and
// raises stall on hazards.
// Build option ID_FORWARD_EN: when defined, operands are forwarded from EX (non-load)
// and MEM and only load-use hazards stall; when undefined, any RAW dependence on a
// writing EX or MEM instruction stalls. The WB same-cycle bypass is always present.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned NREG      = 32,
  parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
  input logic         clk,
  input logic         clrn,
  id_stage_if.slave   bus
);

  logic [31:0] inst_q, pc4_q;
  logic        stall;

  always_ff @(posedge clk) begin
    if (clrn) begin
      inst_q <= '0;
      pc4_q  <= RESET_PC4;
    end else if (!stall) begin
      inst_q <= bus.if_inst;
      pc4_q  <= bus.if_pc4;
    end
  end

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  assign op    = inst_q[31:26];
  assign rs    = inst_q[25:21];
  assign rt    = inst_q[20:16];
  assign rd    = inst_q[15:11];
  assign funct = inst_q[5:0];
  assign imm16 = inst_q[15:0];

  // Decode
  logic       dec_wreg, dec_m2reg, dec_wmem, dec_aluimm, is_rtype;
  logic       is_beq, is_bne, is_j, use_rs, use_rt;
  logic [3:0] dec_aluc;

  always_comb begin
    dec_wreg   = 1'b0;
    dec_m2reg  = 1'b0;
    dec_wmem   = 1'b0;
    dec_aluimm = 1'b0;
    dec_aluc   = ALU_ADD;
    is_rtype   = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_j       = 1'b0;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    case (op)
      OP_RTYPE: begin
        is_rtype = 1'b1;
        case (funct)
          FN_ADD:  dec_aluc = ALU_ADD;
          FN_SUB:  dec_aluc = ALU_SUB;
          FN_AND:  dec_aluc = ALU_AND;
          FN_OR:   dec_aluc = ALU_OR;
          FN_SLT:  dec_aluc = ALU_SLT;
          default: is_rtype = 1'b0;  // unknown funct (incl. inst=0) is a NOP
        endcase
        dec_wreg = is_rtype;
        use_rs   = is_rtype;
        use_rt   = is_rtype;
      end
      OP_ADDI: begin dec_wreg = 1'b1; dec_aluimm = 1'b1; use_rs = 1'b1; end
      OP_ANDI: begin
        dec_wreg = 1'b1; dec_aluimm = 1'b1; use_rs = 1'b1; dec_aluc = ALU_AND;
      end
      OP_ORI: begin
        dec_wreg = 1'b1; dec_aluimm = 1'b1; use_rs = 1'b1; dec_aluc = ALU_OR;
      end
      OP_LUI:  begin dec_wreg = 1'b1; dec_aluimm = 1'b1; dec_aluc = ALU_LUI; end
      OP_LW: begin
        dec_wreg = 1'b1; dec_m2reg = 1'b1; dec_aluimm = 1'b1; use_rs = 1'b1;
      end
      OP_SW: begin
        dec_wmem = 1'b1; dec_aluimm = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_BEQ:  begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_aluc = ALU_SUB; end
      OP_BNE:  begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; dec_aluc = ALU_SUB; end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_ANDI, OP_ORI: bus.imm = {16'h0000, imm16};
      OP_LUI:          bus.imm = {imm16, 16'h0000};
      default:         bus.imm = {{16{imm16[15]}}, imm16};
    endcase
  end

  // Register file
  logic [31:0] rf_a, rf_b;

  id_regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk_i (clk),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rf_a),
    .rd2_o (rf_b),
    .we_i  (bus.wb_we),
    .wn_i  (bus.wb_rn),
    .wd_i  (bus.wb_data)
  );

  // Operand selection and hazard detection
  logic [31:0] da, db;
  logic        hz_a, hz_b;

`ifdef ID_FORWARD_EN
  // A load in EX has no data yet, so it is never a forwarding source.
  logic ex_fwd_a, ex_fwd_b, mem_fwd_a, mem_fwd_b;
  assign ex_fwd_a  = bus.ex_wreg && !bus.ex_m2reg && bus.ex_rn == rs && rs != 5'd0;
  assign ex_fwd_b  = bus.ex_wreg && !bus.ex_m2reg && bus.ex_rn == rt && rt != 5'd0;
  assign mem_fwd_a = bus.mem_wreg && bus.mem_rn == rs && rs != 5'd0;
  assign mem_fwd_b = bus.mem_wreg && bus.mem_rn == rt && rt != 5'd0;

  always_comb begin
    da = rf_a;
    if (ex_fwd_a)       da = bus.ex_alu;
    else if (mem_fwd_a) da = bus.mem_data;
    db = rf_b;
    if (ex_fwd_b)       db = bus.ex_alu;
    else if (mem_fwd_b) db = bus.mem_data;
  end

  logic ex_load;
  assign ex_load = bus.ex_wreg && bus.ex_m2reg && bus.ex_rn != 5'd0;
  assign hz_a    = ex_load && use_rs && bus.ex_rn == rs;
  assign hz_b    = ex_load && use_rt && bus.ex_rn == rt;
`else
  assign da = rf_a;
  assign db = rf_b;

  logic ex_w, mem_w;
  assign ex_w  = bus.ex_wreg && bus.ex_rn != 5'd0;
  assign mem_w = bus.mem_wreg && bus.mem_rn != 5'd0;
  assign hz_a  = use_rs && ((ex_w && bus.ex_rn == rs) || (mem_w && bus.mem_rn == rs));
  assign hz_b  = use_rt && ((ex_w && bus.ex_rn == rt) || (mem_w && bus.mem_rn == rt));

  logic unused_fwd;
  assign unused_fwd = ^{bus.ex_m2reg, bus.ex_alu, bus.mem_data};
`endif

  assign stall = hz_a || hz_b;

  // Outputs; a stall turns the instruction into a bubble towards EX.
  always_comb begin
    bus.pcsource = PC_SEQ;
    if (!stall) begin
      if ((is_beq && da == db) || (is_bne && da != db)) bus.pcsource = PC_BR;
      else if (is_j)                                    bus.pcsource = PC_J;
    end
  end

  assign bus.stall  = stall;
  assign bus.bpc    = pc4_q + {{14{imm16[15]}}, imm16, 2'b00};
  assign bus.jpc    = {pc4_q[31:28], inst_q[25:0], 2'b00};
  assign bus.da     = da;
  assign bus.db     = db;
  assign bus.rn     = is_rtype ? rd : rt;
  assign bus.aluc   = dec_aluc;
  assign bus.aluimm = dec_aluimm;
  assign bus.wreg   = dec_wreg && !stall;
  assign bus.m2reg  = dec_m2reg && !stall;
  assign bus.wmem   = dec_wmem && !stall;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage. Each transaction loads an instruction
// into IF/ID, sets the EX/MEM/WB side inputs, queues the expected outputs and then
// drains the queue against the DUT outputs. Expectations follow ID_FORWARD_EN.
module tb_id_stage;
  import id_stage_pkg::*;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  id_stage_if bus ();

  id_stage #(
    .NREG      (32),
    .RESET_PC4 (32'h0000_0004)
  ) u_dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  localparam int S_STALL = 0, S_PCS = 1, S_WREG = 2, S_WMEM = 3, S_M2REG = 4;
  localparam int S_ALUIMM = 5, S_DA = 6, S_DB = 7, S_IMM = 8, S_RN = 9, S_ALUC = 10;
  localparam int S_BPC = 11, S_JPC = 12;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_STALL:  return {31'd0, bus.stall};
      S_PCS:    return {30'd0, bus.pcsource};
      S_WREG:   return {31'd0, bus.wreg};
      S_WMEM:   return {31'd0, bus.wmem};
      S_M2REG:  return {31'd0, bus.m2reg};
      S_ALUIMM: return {31'd0, bus.aluimm};
      S_DA:     return bus.da;
      S_DB:     return bus.db;
      S_IMM:    return bus.imm;
      S_RN:     return {27'd0, bus.rn};
      S_ALUC:   return {28'd0, bus.aluc};
      S_BPC:    return bus.bpc;
      S_JPC:    return bus.jpc;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic idle_side();
    bus.ex_wreg  = 1'b0; bus.ex_m2reg = 1'b0; bus.ex_rn = '0; bus.ex_alu = '0;
    bus.mem_wreg = 1'b0; bus.mem_rn   = '0;   bus.mem_data = '0;
    bus.wb_we    = 1'b0; bus.wb_rn    = '0;   bus.wb_data  = '0;
  endtask

  // Present an instruction to IF/ID and clock it in; side inputs return to idle after.
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc4);
    bus.if_inst = inst;
    bus.if_pc4  = pc4;
    @(posedge clk);
    #1;
    idle_side();
  endtask

  // Clears any held instruction left behind by a stall.
  task automatic flush();
    idle_side();
    bus.if_inst = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic ex_load(input logic [4:0] r);
    bus.ex_wreg = 1'b1; bus.ex_m2reg = 1'b1; bus.ex_rn = r;
  endtask

  initial begin
    idle_side();
    bus.if_inst = '0;
    bus.if_pc4  = 32'h1234_5678;
    clrn = 1'b1;

    // Reset
    @(posedge clk);
    @(posedge clk);
    #1;
    push("rst_stall", S_STALL, 0);
    push("rst_pcs",   S_PCS,   0);
    push("rst_wreg",  S_WREG,  0);
    push("rst_wmem",  S_WMEM,  0);
    push("rst_pc4",   S_BPC,   32'h4);
    drain();
    clrn = 1'b0;

    // Preload registers; $0 write must be ignored
    for (int i = 0; i < 5; i++) begin
      logic [4:0]  r;
      logic [31:0] v;
      case (i)
        0: begin r = 5'd1; v = 32'h11;   end
        1: begin r = 5'd2; v = 32'h22;   end
        2: begin r = 5'd4; v = 32'h44;   end
        3: begin r = 5'd5; v = 32'h5;    end
        default: begin r = 5'd0; v = 32'hFFFF; end
      endcase
      bus.wb_we = 1'b1; bus.wb_rn = r; bus.wb_data = v;
      @(posedge clk);
      #1;
    end
    idle_side();

    // Zero register read
    issue(rtype(5'd0, 5'd2, 5'd3, FN_OR), 32'h8);
    push("zero_da", S_DA, 0);
    push("zero_db", S_DB, 32'h22);
    push("or_rn",   S_RN, 3);
    push("or_aluc", S_ALUC, ALU_OR);
    push("or_wreg", S_WREG, 1);
    drain();

    // EX forward / stall
    issue(rtype(5'd1, 5'd2, 5'd3, FN_ADD), 32'hC);
    bus.ex_wreg = 1'b1; bus.ex_rn = 5'd1; bus.ex_alu = 32'h10;
`ifdef ID_FORWARD_EN
    push("fwd_ex_stall", S_STALL, 0);
    push("fwd_ex_da",    S_DA,    32'h10);
    push("fwd_ex_db",    S_DB,    32'h22);
    push("fwd_ex_wreg",  S_WREG,  1);
`else
    push("nofwd_ex_stall", S_STALL, 1);
    push("nofwd_ex_wreg",  S_WREG,  0);
`endif
    drain();
    flush();

    // MEM forward / stall
    issue(rtype(5'd2, 5'd1, 5'd6, FN_SUB), 32'h10);
    bus.mem_wreg = 1'b1; bus.mem_rn = 5'd2; bus.mem_data = 32'h99;
`ifdef ID_FORWARD_EN
    push("fwd_mem_da",   S_DA,   32'h99);
    push("fwd_mem_db",   S_DB,   32'h11);
    push("sub_aluc",     S_ALUC, ALU_SUB);
`else
    push("nofwd_mem_stall", S_STALL, 1);
    push("nofwd_mem_pcs",   S_PCS,   0);
`endif
    drain();
    flush();

    // EX beats MEM
    issue(rtype(5'd1, 5'd1, 5'd6, FN_AND), 32'h14);
    bus.ex_wreg  = 1'b1; bus.ex_rn  = 5'd1; bus.ex_alu   = 32'hA;
    bus.mem_wreg = 1'b1; bus.mem_rn = 5'd1; bus.mem_data = 32'hB;
`ifdef ID_FORWARD_EN
    push("prio_da", S_DA, 32'hA);
    push("prio_db", S_DB, 32'hA);
`else
    push("nofwd_prio_stall", S_STALL, 1);
`endif
    drain();
    flush();

    // Load in EX is never a forwarding source
    issue(rtype(5'd1, 5'd2, 5'd3, FN_ADD), 32'h18);
    ex_load(5'd1);
    push("ld_rs_stall", S_STALL, 1);
    push("ld_rs_wreg",  S_WREG,  0);
    drain();
    flush();

    // WB same-cycle bypass, then committed value
    issue(rtype(5'd7, 5'd0, 5'd8, FN_ADD), 32'h1C);
    bus.wb_we = 1'b1; bus.wb_rn = 5'd7; bus.wb_data = 32'h55;
    push("wb_byp_da", S_DA, 32'h55);
    push("wb_byp_db", S_DB, 0);
    drain();
    issue(rtype(5'd7, 5'd4, 5'd8, FN_SLT), 32'h20);
    push("wb_commit_da", S_DA,   32'h55);
    push("wb_commit_db", S_DB,   32'h44);
    push("slt_aluc",     S_ALUC, ALU_SLT);
    drain();

    // Load-use on beq: one stall cycle with IF/ID held
    issue(itype(OP_BEQ, 5'd5, 5'd0, 16'd3), 32'h100);
    ex_load(5'd5);
    push("lu_stall", S_STALL, 1);
    push("lu_wreg",  S_WREG,  0);
    push("lu_wmem",  S_WMEM,  0);
    push("lu_pcs",   S_PCS,   0);
    drain();
    issue({OP_J, 26'h40}, 32'hA000_0008);
    push("lu_held_stall", S_STALL, 0);
    push("lu_held_bpc",   S_BPC,   32'h10C);
    push("lu_held_pcs",   S_PCS,   0);
    drain();

    // Jump (the held j is now loaded)
    issue({OP_J, 26'h40}, 32'hA000_0008);
    push("j_pcs", S_PCS, PC_J);
    push("j_jpc", S_JPC, 32'hA000_0100);
    push("j_wreg", S_WREG, 0);
    drain();

    // lui does not read rs
    issue(itype(OP_LUI, 5'd5, 5'd9, 16'h1234), 32'h24);
    ex_load(5'd5);
    push("lui_stall",  S_STALL,  0);
    push("lui_imm",    S_IMM,    32'h1234_0000);
    push("lui_aluc",   S_ALUC,   ALU_LUI);
    push("lui_aluimm", S_ALUIMM, 1);
    push("lui_rn",     S_RN,     9);
    drain();

    // Branches
    issue(itype(OP_BEQ, 5'd4, 5'd4, 16'hFFFF), 32'h20);
    push("beq_pcs", S_PCS, PC_BR);
    push("beq_bpc", S_BPC, 32'h1C);
    drain();
    issue(itype(OP_BNE, 5'd4, 5'd4, 16'd2), 32'h30);
    push("bne_eq_pcs", S_PCS, PC_SEQ);
    drain();
    issue(itype(OP_BNE, 5'd4, 5'd1, 16'd2), 32'h40);
    push("bne_ne_pcs", S_PCS, PC_BR);
    push("bne_ne_bpc", S_BPC, 32'h48);
    drain();

    // Immediates and memory ops
    issue(itype(OP_ADDI, 5'd1, 5'd10, 16'hFFFE), 32'h44);
    push("addi_imm",  S_IMM,  32'hFFFF_FFFE);
    push("addi_aluc", S_ALUC, ALU_ADD);
    push("addi_rn",   S_RN,   10);
    push("addi_wreg", S_WREG, 1);
    drain();
    issue(itype(OP_ORI, 5'd1, 5'd10, 16'h8001), 32'h48);
    push("ori_imm",  S_IMM,  32'h0000_8001);
    push("ori_aluc", S_ALUC, ALU_OR);
    drain();
    issue(itype(OP_ANDI, 5'd1, 5'd10, 16'hF0F0), 32'h4C);
    push("andi_imm",  S_IMM,  32'h0000_F0F0);
    push("andi_aluc", S_ALUC, ALU_AND);
    drain();
    issue(itype(OP_LW, 5'd1, 5'd11, 16'd8), 32'h50);
    push("lw_m2reg", S_M2REG, 1);
    push("lw_wreg",  S_WREG,  1);
    push("lw_imm",   S_IMM,   32'h8);
    push("lw_da",    S_DA,    32'h11);
    drain();
    issue(itype(OP_SW, 5'd1, 5'd2, 16'hFFFC), 32'h54);
    push("sw_wmem", S_WMEM, 1);
    push("sw_wreg", S_WREG, 0);
    push("sw_db",   S_DB,   32'h22);
    push("sw_imm",  S_IMM,  32'hFFFF_FFFC);
    drain();

    // Unknown opcode is a NOP that reads nothing
    issue(itype(6'h3F, 5'd5, 5'd5, 16'd0), 32'h58);
    ex_load(5'd5);
    push("nop_stall", S_STALL, 0);
    push("nop_wreg",  S_WREG,  0);
    push("nop_wmem",  S_WMEM,  0);
    push("nop_m2reg", S_M2REG, 0);
    push("nop_pcs",   S_PCS,   0);
    drain();

    // Reset mid-operation overrides a pending stall and a taken branch
    issue(itype(OP_BNE, 5'd4, 5'd1, 16'd2), 32'h60);
    push("pre_rst_pcs", S_PCS, PC_BR);
    drain();
    ex_load(5'd4);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    push("mid_rst_stall", S_STALL, 0);
    push("mid_rst_pcs",   S_PCS,   0);
    push("mid_rst_wreg",  S_WREG,  0);
    push("mid_rst_pc4",   S_BPC,   32'h4);
    drain();
    clrn = 1'b0;
    idle_side();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
